// File: rtl/uart_pixel_writer.sv
// uart_pixel_writer
// Pairs bytes from the UART receiver into RGB565 pixels (high byte first)
// and writes them to the frame RAM at sequential addresses. The address
// wraps at the end of the frame. An inter-byte timeout sends a stalled host
// back to pixel 0.

module uart_pixel_writer #(
  parameter int PIXELS  = 16384,
  parameter int ADDR_W  = 14,
  parameter int TIMEOUT = 5_000_000
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  input  logic              clear,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [15:0]       ram_wdata,
  output logic              frame_done,
  output logic              resync
);

  localparam int TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PIXELS - 1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(TIMEOUT - 1);
  localparam logic [TCNT_W-1:0] TCNT_ZERO = '0;
  localparam logic [TCNT_W-1:0] TCNT_ONE  = TCNT_W'(1);

  typedef enum logic {
    S_HI,
    S_LO
  } state_t;

  state_t state_q, state_d;

  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  logic              ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0] ram_waddr_q, ram_waddr_d;
  logic [15:0]       ram_wdata_q, ram_wdata_d;
  logic              frame_done_q, frame_done_d;
  logic              resync_q, resync_d;

  logic              timing_active;
  logic              timeout_hit;
  logic              next_active;

  // The timer only matters while there is partial progress to throw away.
  always_comb begin
    timing_active = (state_q == S_LO) || (addr_q != ADDR_ZERO);
    timeout_hit   = timing_active && (tcnt_q == TCNT_LAST);
  end

  // State register for the byte-pairing FSM.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_HI;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic, pixel assembly, address stepping and timeout handling.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    addr_d       = addr_q;
    tcnt_d       = tcnt_q;
    ram_wren_d   = 1'b0;
    ram_waddr_d  = ram_waddr_q;
    ram_wdata_d  = ram_wdata_q;
    frame_done_d = 1'b0;
    resync_d     = 1'b0;
    next_active  = 1'b0;

    if (clear) begin
      state_d = S_HI;
      addr_d  = ADDR_ZERO;
      tcnt_d  = TCNT_ZERO;
    end else if (rx_done) begin
      unique case (state_q)
        S_HI: begin
          hi_d    = rx_data;
          state_d = S_LO;
        end
        S_LO: begin
          ram_wren_d  = 1'b1;
          ram_waddr_d = addr_q;
          ram_wdata_d = {hi_q, rx_data};
          state_d     = S_HI;
          if (addr_q == ADDR_LAST) begin
            addr_d       = ADDR_ZERO;
            frame_done_d = 1'b1;
          end else begin
            addr_d = addr_q + ADDR_ONE;
          end
        end
        default: state_d = S_HI;
      endcase
      // The strobe cycle itself counts as idle cycle zero, so the counter
      // resumes at one; this lands resync exactly TIMEOUT cycles after the
      // last byte.
      next_active = (state_d == S_LO) || (addr_d != ADDR_ZERO);
      tcnt_d      = next_active ? TCNT_ONE : TCNT_ZERO;
    end else if (timeout_hit) begin
      state_d  = S_HI;
      addr_d   = ADDR_ZERO;
      tcnt_d   = TCNT_ZERO;
      resync_d = 1'b1;
    end else if (timing_active) begin
      tcnt_d = tcnt_q + TCNT_ONE;
    end else begin
      tcnt_d = TCNT_ZERO;
    end
  end

  // Datapath registers; outputs are registered so the RAM sees clean strobes.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hi_q         <= 8'h00;
      addr_q       <= ADDR_ZERO;
      tcnt_q       <= TCNT_ZERO;
      ram_wren_q   <= 1'b0;
      ram_waddr_q  <= ADDR_ZERO;
      ram_wdata_q  <= 16'h0000;
      frame_done_q <= 1'b0;
      resync_q     <= 1'b0;
    end else begin
      hi_q         <= hi_d;
      addr_q       <= addr_d;
      tcnt_q       <= tcnt_d;
      ram_wren_q   <= ram_wren_d;
      ram_waddr_q  <= ram_waddr_d;
      ram_wdata_q  <= ram_wdata_d;
      frame_done_q <= frame_done_d;
      resync_q     <= resync_d;
    end
  end

  assign ram_wren   = ram_wren_q;
  assign ram_waddr  = ram_waddr_q;
  assign ram_wdata  = ram_wdata_q;
  assign frame_done = frame_done_q;
  assign resync     = resync_q;

endmodule
